// File: rtl/match_score_controller_pkg.sv
// Shared types for the match score controller: FSM states and sprite descriptors.
// The sprite ROM layout places the ten digit glyphs consecutively from Zero.
package main_package;

    typedef enum logic [1:0] {
        PLAY,
        BREAK,
        DONE
    } match_state_e;

    typedef enum logic [3:0] {
        Zero, One, Two, Three, Four,
        Five, Six, Seven, Eight, Nine, Blank
    } element_e;

    typedef logic [7:0] pos_in_rom;

    typedef struct packed {
        logic [5:0] w;
        logic [5:0] h;
    } sprite_size;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        sprite_size  size;
        pos_in_rom   idx;
    } element_pos_size_rom;

    localparam sprite_size DIGIT_SIZE = '{w: 6'd16, h: 6'd24};

    localparam pos_in_rom enum_to_index [11] = '{
        8'd4, 8'd5, 8'd6, 8'd7, 8'd8,
        8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd0
    };

endpackage

// File: rtl/match_score_controller_score_digit_split.sv
// Splits a small binary value (< 100) into decimal tens and units.
module score_digit_split #(
    parameter int W = 5
) (
    input  logic [W-1:0] value,
    output logic [3:0]   tens,
    output logic [3:0]   units
);

    assign tens  = 4'(value / 10);
    assign units = 4'(value % 10);

endmodule

// File: rtl/match_score_controller.sv
// Badminton-style match scorer: edge-detected point/undo buttons, game/match
// tracking with a timed between-game freeze, and score sprite descriptors.
module match_score_controller
    import main_package::*;
#(
    parameter int WIN_SCORE    = 21,
    parameter int CAP_SCORE    = 30,
    parameter int LEAD         = 2,
    parameter int GAMES_TO_WIN = 2,
    parameter int BREAK_CYCLES = 50_000_000,
    parameter int SW           = $clog2(CAP_SCORE + 1)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              player1_add_score,
    input  logic                              player2_add_score,
    input  logic                              undo,
    output logic [SW-1:0]                     p1_score,
    output logic [SW-1:0]                     p2_score,
    output logic [$clog2(GAMES_TO_WIN+1)-1:0] p1_games,
    output logic [$clog2(GAMES_TO_WIN+1)-1:0] p2_games,
    output logic                              server,
    output logic                              game_break,
    output logic                              player1_win,
    output logic                              player2_win,
    output element_pos_size_rom               score [6]
);

    localparam int GW = $clog2(GAMES_TO_WIN + 1);
    localparam int CW = $clog2(BREAK_CYCLES + 1);

    match_state_e  state;
    logic [CW-1:0] cnt;
    logic          p1_q, p2_q, undo_q;
    logic          ev1, ev2, evu;
    logic          hv, h_srv;
    logic [SW-1:0] h1, h2;
    logic [SW-1:0] n1, n2;
    logic          pt1, pt2, end1, end2;
    logic          last1, last2;

    assign pt1 = ev1 & ~ev2 & ~evu;
    assign pt2 = ev2 & ~ev1 & ~evu;
    assign n1  = p1_score + 1'b1;
    assign n2  = p2_score + 1'b1;

    // Game end is judged on the post-point score
    assign end1 = (int'(n1) >= WIN_SCORE && int'(n1) - int'(p2_score) >= LEAD)
                || int'(n1) == CAP_SCORE;
    assign end2 = (int'(n2) >= WIN_SCORE && int'(n2) - int'(p1_score) >= LEAD)
                || int'(n2) == CAP_SCORE;
    assign last1 = (p1_games + 1'b1) == GW'(GAMES_TO_WIN);
    assign last2 = (p2_games + 1'b1) == GW'(GAMES_TO_WIN);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state       <= PLAY;
            cnt         <= '0;
            p1_q        <= 1'b0;
            p2_q        <= 1'b0;
            undo_q      <= 1'b0;
            ev1         <= 1'b0;
            ev2         <= 1'b0;
            evu         <= 1'b0;
            hv          <= 1'b0;
            h_srv       <= 1'b0;
            h1          <= '0;
            h2          <= '0;
            p1_score    <= '0;
            p2_score    <= '0;
            p1_games    <= '0;
            p2_games    <= '0;
            server      <= 1'b0;
            game_break  <= 1'b0;
            player1_win <= 1'b0;
            player2_win <= 1'b0;
        end else begin
            p1_q   <= player1_add_score;
            p2_q   <= player2_add_score;
            undo_q <= undo;
            ev1    <= player1_add_score & ~p1_q;
            ev2    <= player2_add_score & ~p2_q;
            evu    <= undo & ~undo_q;
            unique case (state)
                PLAY: begin
                    if (evu) begin
                        if (hv) begin
                            p1_score <= h1;
                            p2_score <= h2;
                            server   <= h_srv;
                            hv       <= 1'b0;
                        end
                    end else if (pt1 || pt2) begin
                        h1    <= p1_score;
                        h2    <= p2_score;
                        h_srv <= server;
                        hv    <= 1'b1;
                        if (pt1) begin
                            p1_score <= n1;
                            server   <= 1'b0;
                        end else begin
                            p2_score <= n2;
                            server   <= 1'b1;
                        end
                        if ((pt1 && end1) || (pt2 && end2)) begin
                            hv <= 1'b0;
                            if (pt1) p1_games <= p1_games + 1'b1;
                            else     p2_games <= p2_games + 1'b1;
                            if ((pt1 && last1) || (pt2 && last2)) begin
                                state       <= DONE;
                                player1_win <= pt1;
                                player2_win <= pt2;
                            end else begin
                                state      <= BREAK;
                                game_break <= 1'b1;
                                cnt        <= '0;
                            end
                        end
                    end
                end
                BREAK: begin
                    if (cnt == CW'(BREAK_CYCLES - 1)) begin
                        cnt        <= '0;
                        p1_score   <= '0;
                        p2_score   <= '0;
                        game_break <= 1'b0;
                        state      <= PLAY;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                end
                default: state <= PLAY;
            endcase
        end
    end

    logic [3:0] p1_t, p1_u, p2_t, p2_u;

    score_digit_split #(.W(SW)) u_split_p1 (
        .value (p1_score),
        .tens  (p1_t),
        .units (p1_u)
    );

    score_digit_split #(.W(SW)) u_split_p2 (
        .value (p2_score),
        .tens  (p2_t),
        .units (p2_u)
    );

    always_comb begin
        score[0] = '{x: 11'd310, y: 10'd25, size: DIGIT_SIZE,
                     idx: pos_in_rom'(p1_t) + enum_to_index[Zero]};
        score[1] = '{x: 11'd330, y: 10'd25, size: DIGIT_SIZE,
                     idx: pos_in_rom'(p1_u) + enum_to_index[Zero]};
        score[2] = '{x: 11'd380, y: 10'd25, size: DIGIT_SIZE,
                     idx: pos_in_rom'(p2_t) + enum_to_index[Zero]};
        score[3] = '{x: 11'd400, y: 10'd25, size: DIGIT_SIZE,
                     idx: pos_in_rom'(p2_u) + enum_to_index[Zero]};
        score[4] = '{x: 11'd340, y: 10'd55, size: DIGIT_SIZE,
                     idx: pos_in_rom'(p1_games) + enum_to_index[Zero]};
        score[5] = '{x: 11'd370, y: 10'd55, size: DIGIT_SIZE,
                     idx: pos_in_rom'(p2_games) + enum_to_index[Zero]};
    end

endmodule

// File: tb/tb_match_score_controller.sv
// Bench for match_score_controller: action table, directed game/match
// scenarios, and random button traffic against a rule-level model.
module tb_match_score_controller;
    import main_package::*;

    localparam int SW = 5;
    localparam int GW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic p1 = 1'b0, p2 = 1'b0, un = 1'b0;
    logic [SW-1:0] s1, s2;
    logic [GW-1:0] g1, g2;
    logic srv, gb, w1, w2;
    element_pos_size_rom spr [6];

    match_score_controller #(.BREAK_CYCLES(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .player1_add_score (p1),
        .player2_add_score (p2),
        .undo              (un),
        .p1_score          (s1),
        .p2_score          (s2),
        .p1_games          (g1),
        .p2_games          (g2),
        .server            (srv),
        .game_break        (gb),
        .player1_win       (w1),
        .player2_win       (w2),
        .score             (spr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Rule-level model: scores, games, server, one-deep undo history
    int m_s[2], m_g[2], m_h[2];
    int m_srv, m_hsrv, m_hv, m_done, m_pend;

    function automatic void m_reset();
        m_s = '{0, 0}; m_g = '{0, 0}; m_h = '{0, 0};
        m_srv = 0; m_hsrv = 0; m_hv = 0; m_done = 0; m_pend = 0;
    endfunction

    function automatic void m_act(input int a);
        int w, lead;
        if (m_done != 0 || m_pend != 0) return;
        if (a == 3 || a == 5) begin
            if (m_hv != 0) begin
                m_s = m_h; m_srv = m_hsrv; m_hv = 0;
            end
            return;
        end
        if (a == 4) return;
        w = a - 1;
        m_h = m_s; m_hsrv = m_srv;
        m_s[w]++;
        m_srv = w;
        lead = m_s[w] - m_s[1-w];
        if ((m_s[w] >= 21 && lead >= 2) || m_s[w] == 30) begin
            m_hv = 0;
            m_g[w]++;
            if (m_g[w] == 2) m_done = 1;
            else m_pend = 1;
        end else begin
            m_hv = 1;
        end
    endfunction

    function automatic void m_end_break();
        if (m_pend != 0) begin
            m_s = '{0, 0}; m_pend = 0;
        end
    endfunction

    // 1=p1 2=p2 3=undo 4=p1+p2 5=p1+undo; one-cycle pulse, sampled after apply
    task automatic act(input int a);
        @(negedge clk);
        p1 = (a == 1 || a == 4 || a == 5);
        p2 = (a == 2 || a == 4);
        un = (a == 3 || a == 5);
        @(negedge clk);
        p1 = 0; p2 = 0; un = 0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        p1 = 0; p2 = 0; un = 0;
        rst_n = 1;
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
    endtask

    task automatic chk_zero(input string t);
        chk({t, "_s1"}, int'(s1), 0);
        chk({t, "_s2"}, int'(s2), 0);
        chk({t, "_g1"}, int'(g1), 0);
        chk({t, "_g2"}, int'(g2), 0);
        chk({t, "_srv"}, int'(srv), 0);
        chk({t, "_brk"}, int'(gb), 0);
        chk({t, "_w1"}, int'(w1), 0);
        chk({t, "_w2"}, int'(w2), 0);
    endtask

    task automatic chk_model(input string t);
        chk({t, "_s1"}, int'(s1), m_s[0]);
        chk({t, "_s2"}, int'(s2), m_s[1]);
        chk({t, "_srv"}, int'(srv), m_srv);
        chk({t, "_g1"}, int'(g1), m_g[0]);
        chk({t, "_g2"}, int'(g2), m_g[1]);
        chk({t, "_w1"}, int'(w1), int'(m_done != 0 && m_g[0] == 2));
        chk({t, "_w2"}, int'(w2), int'(m_done != 0 && m_g[1] == 2));
    endtask

    typedef struct {
        int act;
        int e1;
        int e2;
        int esrv;
    } vec_t;

    vec_t tv [15];
    int z;

    initial begin
        tv = '{
            '{1, 1, 0, 0}, '{1, 2, 0, 0}, '{1, 3, 0, 0}, '{1, 4, 0, 0},
            '{2, 4, 1, 1}, '{2, 4, 2, 1}, '{2, 4, 3, 1}, '{1, 5, 3, 0},
            '{3, 4, 3, 1}, '{3, 4, 3, 1}, '{4, 4, 3, 1}, '{3, 4, 3, 1},
            '{2, 4, 4, 1}, '{5, 4, 3, 1}, '{3, 4, 3, 1}
        };
        z = int'(enum_to_index[Zero]);

        do_reset();
        chk_zero("reset");

        foreach (tv[i]) begin
            act(tv[i].act);
            chk($sformatf("tv%0d_s1", i), int'(s1), tv[i].e1);
            chk($sformatf("tv%0d_s2", i), int'(s2), tv[i].e2);
            chk($sformatf("tv%0d_srv", i), int'(srv), tv[i].esrv);
        end

        // Held level: one point only
        @(negedge clk);
        p1 = 1;
        idle(100);
        p1 = 0;
        idle(2);
        chk("held_s1", int'(s1), 5);
        chk("held_s2", int'(s2), 3);
        chk("held_srv", int'(srv), 0);
        chk("spr_p1u", int'(spr[1].idx), z + 5);
        chk("spr_p1t", int'(spr[0].idx), z);
        chk("spr_p2u", int'(spr[3].idx), z + 3);
        chk("spr_g1", int'(spr[4].idx), z);
        chk("spr_x2", int'(spr[2].x), 380);
        chk("spr_y5", int'(spr[5].y), 55);
        chk("spr_y0", int'(spr[0].y), 25);

        // Deuce to 23-21
        do_reset();
        repeat (20) begin act(1); act(2); end
        act(1); act(2); act(1); act(1);
        chk("deuce_s1", int'(s1), 23);
        chk("deuce_s2", int'(s2), 21);
        chk("deuce_g1", int'(g1), 1);
        chk("deuce_brk", int'(gb), 1);
        chk("deuce_spr_t", int'(spr[0].idx), z + 2);
        chk("deuce_spr_u", int'(spr[1].idx), z + 3);
        chk("deuce_spr_g", int'(spr[4].idx), z + 1);
        idle(6);
        chk("after_brk_s1", int'(s1), 0);
        chk("after_brk_brk", int'(gb), 0);
        chk("after_brk_srv", int'(srv), 0);

        // Cap at 30
        do_reset();
        repeat (29) begin act(1); act(2); end
        act(2);
        chk("cap_s1", int'(s1), 29);
        chk("cap_s2", int'(s2), 30);
        chk("cap_g2", int'(g2), 1);
        chk("cap_srv", int'(srv), 1);
        chk("cap_brk", int'(gb), 1);

        // Straight 21-0, points ignored in break, then match
        do_reset();
        repeat (21) act(1);
        chk("g1_s1", int'(s1), 21);
        chk("g1_s2", int'(s2), 0);
        chk("g1_g1", int'(g1), 1);
        chk("g1_brk", int'(gb), 1);
        act(2);
        chk("brk_ign_s2", int'(s2), 0);
        chk("brk_ign_s1", int'(s1), 21);
        idle(6);
        chk("g2_start", int'(s1), 0);
        repeat (21) act(1);
        chk("match_g1", int'(g1), 2);
        chk("match_w1", int'(w1), 1);
        chk("match_w2", int'(w2), 0);
        chk("match_brk", int'(gb), 0);
        act(2); act(3);
        idle(20);
        chk("done_s1", int'(s1), 21);
        chk("done_s2", int'(s2), 0);
        chk("done_w1", int'(w1), 1);

        // Reset during break
        do_reset();
        repeat (21) act(1);
        chk("pre_rst_brk", int'(gb), 1);
        do_reset();
        chk_zero("mid_brk_rst");
        act(2);
        chk("post_rst_s2", int'(s2), 1);

        // Random traffic against the model
        do_reset();
        m_reset();
        for (int i = 0; i < 250; i++) begin
            int r, a;
            r = int'($urandom_range(0, 11));
            a = (r < 6) ? 1 : (r < 9) ? 2 : (r < 10) ? 3 : (r < 11) ? 4 : 5;
            act(a);
            m_act(a);
            idle(6);
            m_end_break();
            chk_model($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/match_score_controller.md
MATCH_SCORE_CONTROLLER -- requirements
Module: match_score_controller

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 21, meaning points needed to take a game.
REQ-002 SHALL have parameter CAP_SCORE, default 30, meaning the score that wins a game regardless of lead.
REQ-003 SHALL have parameter LEAD, default 2, meaning the minimum winning margin below CAP_SCORE.
REQ-004 SHALL have parameter GAMES_TO_WIN, default 2, meaning games needed to take the match (best of 2*GAMES_TO_WIN-1).
REQ-005 SHALL have parameter BREAK_CYCLES, default 50_000_000, meaning the length of the between-game freeze in clk cycles.
REQ-006 SHALL have parameter SW, fixed to $clog2(CAP_SCORE+1), meaning the score register width.
REQ-007 SHALL have port clk, input, 1 bit: the single clock.
REQ-008 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-high.
REQ-009 SHALL have port player1_add_score, input, 1 bit: player 1 point request, level (held for multiple cycles).
REQ-010 SHALL have port player2_add_score, input, 1 bit: player 2 point request, level.
REQ-011 SHALL have port undo, input, 1 bit: revoke the last accepted point, level.
REQ-012 SHALL have port p1_score and p2_score, output, SW bits each: current game points.
REQ-013 SHALL have port p1_games and p2_games, output, $clog2(GAMES_TO_WIN+1) bits each: games won.
REQ-014 SHALL have port server, output, 1 bit: 0 means player 1 serves, 1 means player 2 serves.
REQ-015 SHALL have port game_break, output, 1 bit: high during the between-game freeze.
REQ-016 SHALL have ports player1_win and player2_win, output, 1 bit each: match won.
REQ-017 SHALL have port score, output, element_pos_size_rom[6]: sprites in this order — p1 tens, p1 units, p2 tens, p2 units, p1 games, p2 games.

Function
REQ-018 Each level input SHALL be rising-edge detected against a registered previous sample; one press yields exactly one event.
REQ-019 SHALL implement an FSM with states PLAY, BREAK and DONE.
REQ-020 In PLAY, a single point event detected at edge N SHALL update the score at edge N+1 (one-cycle latency).
REQ-021 When both point events arrive in the same cycle, they SHALL be ignored; undo arriving with a point SHALL take priority.
REQ-022 The game SHALL end when the winner's new score >= WIN_SCORE with lead >= LEAD, or when the new score == CAP_SCORE; this check is evaluated on the next-score value in the same edge as the update.
REQ-023 On game end, the winner's games count SHALL increment on that edge; if it reaches GAMES_TO_WIN, go to DONE and raise the matching *_win, otherwise go to BREAK.
REQ-024 BREAK SHALL freeze scores and count BREAK_CYCLES, then clear both scores, keep server (last game's winner), and return to PLAY.
REQ-025 DONE SHALL ignore all inputs until reset; the winning flags SHALL stay high.
REQ-026 server SHALL equal the player who won the last accepted rally.
REQ-027 Undo SHALL restore the score and server held before the last accepted point in PLAY; there is one level of history only; a second undo, or an undo with no history, SHALL be ignored.
REQ-028 The undo history SHALL be cleared on game end, so no undo across games.
REQ-029 Points and undo SHALL be ignored in BREAK and DONE.
REQ-030 Scores SHALL never exceed CAP_SCORE; no wrap-around.
REQ-031 score sprites SHALL be combinational from registered state: tens and units via decimal split, index = digit + enum_to_index[Zero], x positions 310, 330, 380, 400, 340, 370; y = 25 for scores and 55 for games.

Reset
REQ-032 rst_n high at an edge SHALL set: scores 0, games 0, server 0, game_break 0, player1_win/player2_win 0, state PLAY, break counter 0, history empty, edge registers 0.
REQ-033 Reset SHALL override any operation in progress, including mid-BREAK and DONE.

Structure
REQ-034 The state enum and element_pos_size_rom use, sprite_size, pos_in_rom and enum_to_index SHALL come from main_package; the FSM enum SHALL be added there.
REQ-035 SHALL contain one sub-module, score_digit_split, which converts an SW-bit value to tens and units.

Verification
REQ-036 A bench SHALL cover: 21 p1 presses from 0-0 -> p1_games=1, game_break=1, scores frozen at 21-0.
REQ-037 A bench SHALL cover: 20-20 then p1, p2, p1, p1 -> game at 23-21 won by p1.
REQ-038 A bench SHALL cover: 29-29 then p2 -> game to p2 at 30-29.
REQ-039 A bench SHALL cover: 5-3 after a p1 point, undo, undo -> 4-3 restored, server restored, second undo ignored.
REQ-040 A bench SHALL cover: simultaneous p1 and p2 edges -> no change; a held level for 100 cycles -> +1 only.
REQ-041 A bench SHALL cover: p1 wins two games (BREAK_CYCLES=4) -> player1_win=1 and later presses ignored; reset mid-BREAK -> all outputs 0.
